// File: rtl/hms_pkg.sv
// Shared limits, field widths and the 12-hour display helper for the hms timekeeper.
package hms_pkg;

    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned HOUR_MAX = 23;

    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned HOUR_W = 5;

    // 0 -> 12, 13..23 -> 1..11, 1..12 unchanged
    function automatic logic [HOUR_W-1:0] to_12h(input logic [HOUR_W-1:0] h);
        if (h == '0)
            return HOUR_W'(12);
        if (h > HOUR_W'(12))
            return h - HOUR_W'(12);
        return h;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) counter with synchronous load; carry flags the enabled MAX -> 0 step.
module mod_counter #(
    parameter int unsigned W   = 6,
    parameter int unsigned MAX = 59
) (
    input  logic         clk,
    input  logic         async_rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] q,
    output logic         carry
);

    logic [W-1:0] q_q, q_d;
    logic         at_max;

    assign at_max = (q_q == W'(MAX));
    assign carry  = at_max & en;
    assign q      = q_q;

    always_comb begin
        q_d = q_q;
        if (load)
            q_d = load_val;
        else if (en)
            q_d = at_max ? '0 : q_q + 1'b1;
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst)
            q_q <= '0;
        else
            q_q <= q_d;
    end

endmodule

// File: rtl/hms_clock_cfg.sv
// Hours/minutes/seconds timekeeper: prescaled second tick, validated time set,
// alarm compare and 12/24-hour display mapping of a 24-hour internal time.
module hms_clock_cfg
    import hms_pkg::*;
#(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        async_rst,
    input  logic        run,
    input  logic        mode_24,
    input  logic        set_valid,
    input  logic [4:0]  set_hours,
    input  logic [5:0]  set_minutes,
    input  logic [5:0]  set_seconds,
    input  logic        alarm_en,
    input  logic [4:0]  alarm_hours,
    input  logic [5:0]  alarm_minutes,
    output logic [4:0]  hours,
    output logic [5:0]  minutes,
    output logic [5:0]  seconds,
    output logic        pm,
    output logic        sec_tick,
    output logic        day_wrap,
    output logic        set_err,
    output logic        alarm_hit
);

    localparam int unsigned       PRE_W    = $clog2(CLK_DIV) + 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CLK_DIV - 1);

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic              sec_tick_q, sec_tick_d;
    logic              day_wrap_q, day_wrap_d;
    logic              set_err_q, set_err_d;
    logic              alarm_hit_q, alarm_hit_d;

    logic [SEC_W-1:0]  sec_q;
    logic [MIN_W-1:0]  min_q, next_min;
    logic [HOUR_W-1:0] hour_q, next_hour;
    logic              sec_carry, min_carry, hour_carry;
    logic              set_ok, tick, adv;

    assign set_ok = set_valid
                  && (set_hours   <= HOUR_W'(HOUR_MAX))
                  && (set_minutes <= MIN_W'(MIN_MAX))
                  && (set_seconds <= SEC_W'(SEC_MAX));
    assign tick = run && (pre_q == PRE_LAST);
    // A valid load swallows a coincident tick
    assign adv  = tick && !set_ok;

    mod_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
        .clk(clk), .async_rst(async_rst), .en(adv), .load(set_ok),
        .load_val(set_seconds), .q(sec_q), .carry(sec_carry)
    );

    mod_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
        .clk(clk), .async_rst(async_rst), .en(sec_carry), .load(set_ok),
        .load_val(set_minutes), .q(min_q), .carry(min_carry)
    );

    mod_counter #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour (
        .clk(clk), .async_rst(async_rst), .en(min_carry), .load(set_ok),
        .load_val(set_hours), .q(hour_q), .carry(hour_carry)
    );

    // Alarm is only possible when seconds roll to 0, so compare the post-carry hh:mm
    assign next_min  = min_carry ? '0 : min_q + 1'b1;
    assign next_hour = hour_carry ? '0 : (min_carry ? hour_q + 1'b1 : hour_q);

    always_comb begin
        pre_d = pre_q;
        if (set_ok)
            pre_d = '0;
        else if (run)
            pre_d = tick ? '0 : pre_q + 1'b1;

        sec_tick_d  = adv;
        day_wrap_d  = hour_carry;
        set_err_d   = set_valid && !set_ok;
        alarm_hit_d = adv && alarm_en && sec_carry
                   && (next_hour == alarm_hours) && (next_min == alarm_minutes);
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            pre_q       <= '0;
            sec_tick_q  <= 1'b0;
            day_wrap_q  <= 1'b0;
            set_err_q   <= 1'b0;
            alarm_hit_q <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            sec_tick_q  <= sec_tick_d;
            day_wrap_q  <= day_wrap_d;
            set_err_q   <= set_err_d;
            alarm_hit_q <= alarm_hit_d;
        end
    end

    assign hours     = mode_24 ? hour_q : to_12h(hour_q);
    assign minutes   = min_q;
    assign seconds   = sec_q;
    assign pm        = (hour_q >= HOUR_W'(12));
    assign sec_tick  = sec_tick_q;
    assign day_wrap  = day_wrap_q;
    assign set_err   = set_err_q;
    assign alarm_hit = alarm_hit_q;

endmodule
